// File: rtl/ifetch_axi_master.sv
// Instruction-fetch AXI read master with a single BURST_LEN-word line buffer.
// Hits are answered combinationally; misses refill the aligned line with one INCR burst.
module ifetch_axi_master #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int BURST_LEN = 4,
  parameter int MASTER_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              if_err,
  output logic              if_stall,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [LEN_W-1:0]  ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam int WORD_W = $clog2(BURST_LEN);
  localparam int OFF    = WORD_W + 2;
  localparam int TAG_W  = ADDR_W - OFF;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_ERR} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_line_valid;
  logic [TAG_W-1:0]    r_tag;
  logic [TAG_W-1:0]    r_req_tag;
  logic [WORD_W-1:0]   r_cnt;
  logic                r_err_flag;
  logic                r_flush_pend;
  logic [DATA_W-1:0]   r_buf [BURST_LEN];

  logic [TAG_W-1:0]    w_tag;
  logic [WORD_W-1:0]   w_word;
  logic                w_hit;
  logic                w_miss;
  logic                w_beat;
  logic                w_beat_err;
  logic                w_burst_err;
  logic                w_unused_bits;

  assign w_tag         = if_addr[ADDR_W-1:OFF];
  assign w_word        = if_addr[OFF-1:2];
  assign w_unused_bits = ^{RID, if_addr[1:0]};

  assign w_hit  = if_req & r_line_valid & (w_tag == r_tag) & ~if_flush & (r_state == S_IDLE);
  assign w_miss = if_req & ~w_hit & ~if_flush & (r_state == S_IDLE);

  assign w_beat      = (r_state == S_R) & RVALID;
  assign w_beat_err  = (RRESP != 2'b00);
  // The last beat's own response counts toward the burst error.
  assign w_burst_err = r_err_flag | w_beat_err;

  assign if_valid = w_hit | (r_state == S_ERR);
  assign if_err   = (r_state == S_ERR);
  assign if_inst  = w_hit ? r_buf[w_word] : '0;
  assign if_stall = if_req & ~if_valid;

  assign ARID    = ID_W'(MASTER_ID);
  assign ARADDR  = {r_req_tag, {OFF{1'b0}}};
  assign ARLEN   = LEN_W'(BURST_LEN - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    case (r_state)
      S_IDLE: if (w_miss) w_next = S_AR;
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_next = S_R;
      end
      S_R: begin
        RREADY = 1'b1;
        if (RVALID & RLAST) w_next = w_burst_err ? S_ERR : S_IDLE;
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_valid <= 1'b0;
      r_tag        <= '0;
      r_req_tag    <= '0;
      r_cnt        <= '0;
      r_err_flag   <= 1'b0;
      r_flush_pend <= 1'b0;
      for (int unsigned i = 0; i < BURST_LEN; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_flush) r_line_valid <= 1'b0;
          if (w_miss)   r_req_tag    <= w_tag;
        end
        S_AR: begin
          if (if_flush) r_flush_pend <= 1'b1;
          if (ARREADY)  r_cnt        <= '0;
        end
        S_R: begin
          if (if_flush) r_flush_pend <= 1'b1;
          if (w_beat) begin
            r_buf[r_cnt] <= RDATA;
            r_cnt        <= r_cnt + 1'b1;
            if (w_beat_err) r_err_flag <= 1'b1;
            if (RLAST) begin
              r_flush_pend <= 1'b0;
              // A flush landing on the final beat still discards the line.
              if (w_burst_err | r_flush_pend | if_flush) begin
                r_line_valid <= 1'b0;
              end else begin
                r_line_valid <= 1'b1;
                r_tag        <= r_req_tag;
              end
            end
          end
        end
        S_ERR:   r_err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_axi_master.sv
// Bench for ifetch_axi_master: directed scenarios plus randomized fetches against a line-buffer model.
module tb_ifetch_axi_master;

  localparam int LB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic [31:0] if_inst;
  logic        if_valid, if_err, if_stall;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [3:0]  RID = '0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;

  int checks = 0;
  int failures = 0;

  bit          m_valid = 1'b0;
  logic [31:0] m_line = '0;
  logic [31:0] mem [logic [31:0]];

  ifetch_axi_master #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .BURST_LEN(4), .MASTER_ID(0)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_inst(if_inst), .if_valid(if_valid), .if_err(if_err), .if_stall(if_stall),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit t=%0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full miss: request, AR phase, 4 beats, then the completion cycle.
  task automatic do_miss(input logic [31:0] addr, input int ar_delay, input int gap,
                         input int err_beat, input int flush_beat, input bit drop_req);
    logic [31:0] line;
    line = addr & ~32'(LB - 1);
    tick();
    if_req = 1'b1; if_addr = addr; if_flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_valid, if_stall, ARVALID} !== 3'b010) begin
      failures++; $display("FAIL miss_start addr=%h got v/stall/arv=%b exp=010", addr, {if_valid, if_stall, ARVALID});
    end
    for (int k = 0; k <= ar_delay; k++) begin
      tick();
      ARREADY = (k == ar_delay) ? 1'b1 : 1'b0;
      if (drop_req) if_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({ARVALID, RREADY, if_valid} !== 3'b100) begin
        failures++; $display("FAIL ar_phase got arv/rr/v=%b exp=100", {ARVALID, RREADY, if_valid});
      end
      checks++;
      if (ARADDR !== line) begin
        failures++; $display("FAIL araddr got=%h exp=%h", ARADDR, line);
      end
      checks++;
      if ({ARID, ARLEN, ARSIZE, ARBURST} !== {4'd0, 4'd3, 3'd2, 2'd1}) begin
        failures++; $display("FAIL ar_fields got id=%0d len=%0d size=%0d burst=%0d exp 0/3/2/1", ARID, ARLEN, ARSIZE, ARBURST);
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = $urandom; RRESP = 2'($urandom); RLAST = 1'($urandom);
        if_flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({ARVALID, RREADY, if_valid, if_stall} !== {3'b010, if_req}) begin
          failures++; $display("FAIL r_gap got arv/rr/v/stall=%b exp=%b", {ARVALID, RREADY, if_valid, if_stall}, {3'b010, if_req});
        end
      end
      tick();
      ARREADY = 1'b0; RVALID = 1'b1; RDATA = mem_word(line + 32'(4 * i));
      RRESP = (i == err_beat) ? 2'b10 : 2'b00;
      RLAST = (i == 3) ? 1'b1 : 1'b0;
      if_flush = (i == flush_beat) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if ({ARVALID, RREADY, if_valid, if_stall} !== {3'b010, if_req}) begin
        failures++; $display("FAIL r_beat%0d got arv/rr/v/stall=%b exp=%b", i, {ARVALID, RREADY, if_valid, if_stall}, {3'b010, if_req});
      end
    end
    tick();
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; if_flush = 1'b0;
    if (err_beat >= 0) begin
      if_req = 1'b1; if_addr = addr;
      @(negedge clk);
      checks++;
      if ({if_valid, if_err, if_stall, ARVALID} !== 4'b1100 || if_inst !== 32'h0) begin
        failures++; $display("FAIL err_cycle got v/err/stall/arv=%b inst=%h exp=1100 inst=0", {if_valid, if_err, if_stall, ARVALID}, if_inst);
      end
      m_valid = 1'b0;
    end else if (flush_beat >= 0) begin
      if_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_valid, if_err, ARVALID, RREADY} !== 4'b0000) begin
        failures++; $display("FAIL flushed_end got v/err/arv/rr=%b exp=0000", {if_valid, if_err, ARVALID, RREADY});
      end
      m_valid = 1'b0;
    end else begin
      if_req = 1'b1; if_addr = addr;
      @(negedge clk);
      checks++;
      if ({if_valid, if_err, if_stall} !== 3'b100 || if_inst !== mem_word(addr)) begin
        failures++; $display("FAIL fill_hit addr=%h got v/err/stall=%b inst=%h exp=100 inst=%h", addr, {if_valid, if_err, if_stall}, if_inst, mem_word(addr));
      end
      m_valid = 1'b1; m_line = line;
    end
  endtask

  task automatic test_reset();
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    checks++;
    if ({ARVALID, RREADY, if_valid, if_err, if_stall} !== 5'b00001) begin
      failures++; $display("FAIL reset_outputs got arv/rr/v/err/stall=%b exp=00001", {ARVALID, RREADY, if_valid, if_err, if_stall});
    end
    tick();
    if_req = 1'b0; rst = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic test_cold_miss();
    mem[32'h0] = 32'h11; mem[32'h4] = 32'h22; mem[32'h8] = 32'h33; mem[32'hC] = 32'h44;
    do_miss(32'h8, 0, 0, -1, -1, 1'b0);
    checks++;
    if (if_inst !== 32'h33) begin
      failures++; $display("FAIL cold_inst got=%h exp=00000033", if_inst);
    end
  endtask

  task automatic test_hits();
    logic [31:0] a [3];
    logic [31:0] e [3];
    a[0] = 32'h0;  a[1] = 32'h4;  a[2] = 32'hC;
    e[0] = 32'h11; e[1] = 32'h22; e[2] = 32'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      if_req = 1'b1; if_addr = a[i];
      @(negedge clk);
      checks++;
      if ({if_valid, ARVALID, if_stall} !== 3'b100 || if_inst !== e[i]) begin
        failures++; $display("FAIL hit_%0d got v/arv/stall=%b inst=%h exp=100 inst=%h", i, {if_valid, ARVALID, if_stall}, if_inst, e[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_miss(32'h40, 5, 2, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if_req = 1'b1; if_addr = 32'h40 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_inst !== mem_word(if_addr)) begin
        failures++; $display("FAIL stall_word%0d got v=%b inst=%h exp v=1 inst=%h", i, if_valid, if_inst, mem_word(if_addr));
      end
    end
  endtask

  task automatic test_flush();
    do_miss(32'h80, 0, 0, -1, 1, 1'b0);
    do_miss(32'h84, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_error();
    do_miss(32'h100, 0, 0, 0, -1, 1'b0);
    do_miss(32'h100, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    tick();
    if_req = 1'b1; if_addr = 32'h4;
    tick();
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      RVALID = 1'b1; RDATA = $urandom; RRESP = 2'b00; RLAST = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({ARVALID, RREADY, if_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_mid_burst got arv/rr/v=%b exp=000", {ARVALID, RREADY, if_valid});
    end
    m_valid = 1'b0;
    tick();
    RLAST = 1'b1;
    tick();
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({RREADY, ARVALID} !== 2'b00) begin
      failures++; $display("FAIL post_reset_beat got rr/arv=%b exp=00", {RREADY, ARVALID});
    end
    tick();
    RVALID = 1'b0; RLAST = 1'b0;
    do_miss(32'h100, 0, 0, -1, -1, 1'b0);
    do_miss(32'h0, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] line;
    bit          fl;
    int          r;
    for (int n = 0; n < 40; n++) begin
      line = 32'($urandom_range(0, 7) * LB);
      addr = line + 32'($urandom_range(0, LB - 1));
      fl   = ($urandom_range(0, 9) == 0);
      if (fl || (m_valid && line == m_line)) begin
        tick();
        if_req = 1'b1; if_addr = addr; if_flush = fl;
        @(negedge clk);
        if (fl) begin
          checks++;
          if ({if_valid, ARVALID} !== 2'b00) begin
            failures++; $display("FAIL rnd_flush addr=%h got v/arv=%b exp=00", addr, {if_valid, ARVALID});
          end
          m_valid = 1'b0;
        end else begin
          checks++;
          if ({if_valid, if_err, if_stall, ARVALID} !== 4'b1000 || if_inst !== mem_word(addr)) begin
            failures++; $display("FAIL rnd_hit addr=%h got v/err/stall/arv=%b inst=%h exp=1000 inst=%h", addr, {if_valid, if_err, if_stall, ARVALID}, if_inst, mem_word(addr));
          end
        end
        if_flush = 1'b0;
      end else begin
        r = int'($urandom_range(0, 9));
        do_miss(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                (r == 0) ? int'($urandom_range(0, 3)) : -1,
                (r == 1) ? int'($urandom_range(0, 3)) : -1,
                ($urandom_range(0, 3) == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_stall();
    test_flush();
    test_error();
    test_reset_mid_burst();
    test_random();
    tick();
    if_req = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
